// File: rtl/block_fetch_pkg.sv
// Shared chunk geometry, block types and position helpers for the cache and its miss handler.
package block_fetch_pkg;

   localparam int unsigned CHUNK_WIDTH  = 16;
   localparam int unsigned COORD_W      = $clog2(CHUNK_WIDTH);
   localparam int unsigned CHUNK_ADDR_W = 3 * COORD_W;
   localparam int unsigned BLOCK_W      = 8;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t z;
   } BlockPos;

   typedef logic [BLOCK_W-1:0] BlockType;

   localparam BlockType BLOCK_AIR   = '0;
   // Most negative coordinate doubles as the "no position" tag.
   localparam coord_t   TAG_INVALID = {1'b1, {(COORD_W-1){1'b0}}};

   function automatic logic pos_is_invalid(input BlockPos p);
      return (p.x == TAG_INVALID) || (p.y == TAG_INVALID) || (p.z == TAG_INVALID);
   endfunction

   // Offsetting by +W/2 is just an MSB flip; layout is {y, z, x} with x in the LSBs.
   function automatic logic [CHUNK_ADDR_W-1:0] block_pos_to_addr(input BlockPos p);
      return {~p.y[COORD_W-1], p.y[COORD_W-2:0],
              ~p.z[COORD_W-1], p.z[COORD_W-2:0],
              ~p.x[COORD_W-1], p.x[COORD_W-2:0]};
   endfunction

endpackage

// File: rtl/block_fetch_if.sv
// Miss-request, chunk BRAM and fill signals between l1_cache and block_fetch.
interface block_fetch_if #(
   parameter int unsigned N = 4
);
   import block_fetch_pkg::*;

   localparam int unsigned PortW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]            miss_valid;
   BlockPos [N-1:0]         miss_pos;
   logic [N-1:0]            miss_ready;
   logic                    mem_en;
   logic [CHUNK_ADDR_W-1:0] mem_addr;
   BlockType                mem_data;
   logic                    fill_valid;
   logic [PortW-1:0]        fill_port;
   BlockPos                 fill_pos;
   BlockType                fill_block;
   logic                    busy;

   modport master (
      output miss_valid, miss_pos, mem_data,
      input  miss_ready, mem_en, mem_addr, fill_valid, fill_port, fill_pos, fill_block, busy
   );

   modport slave (
      input  miss_valid, miss_pos, mem_data,
      output miss_ready, mem_en, mem_addr, fill_valid, fill_port, fill_pos, fill_block, busy
   );

endinterface

// File: rtl/block_fetch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer that advances past the winner.
module block_fetch_rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_i,
   input  logic            advance_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] gnt_idx_o,
   output logic            gnt_any_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [N-1:0]    masked;
   logic [N-1:0]    pick;

   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req_i[i] && (i >= int'(ptr_q));
      end
      // Fall back to the unmasked requests once nothing at or above the pointer is asking.
      pick      = (|masked) ? masked : req_i;
      gnt_o     = pick & ~(pick - 1'b1);
      gnt_any_o = |req_i;
      gnt_idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) begin
            gnt_idx_o = IdxW'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && gnt_any_o) begin
         ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/block_fetch.sv
// Cache miss handler: arbitrates per-port misses, reads the chunk BRAM and returns one-cycle fills.
module block_fetch
   import block_fetch_pkg::*;
#(
   parameter int unsigned N            = 4,
   parameter int unsigned BRAM_LATENCY = 2
) (
   input logic          clk_in,
   input logic          rst_in,
   block_fetch_if.slave bus
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CntW = $clog2(BRAM_LATENCY + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StFill  = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   BlockPos                 req_pos_q, req_pos_d;
   logic [IdxW-1:0]         req_port_q, req_port_d;
   logic                    mem_en_q, mem_en_d;
   logic [CHUNK_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic                    fill_valid_q, fill_valid_d;
   logic [IdxW-1:0]         fill_port_q, fill_port_d;
   BlockPos                 fill_pos_q, fill_pos_d;
   BlockType                fill_block_q, fill_block_d;

   logic [N-1:0]    gnt;
   logic [IdxW-1:0] gnt_idx;
   logic            gnt_any;
   logic            grant_fire;
   BlockPos         gnt_pos;

   assign grant_fire = (state_q == StIdle) && gnt_any;
   assign gnt_pos    = bus.miss_pos[gnt_idx];

   block_fetch_rr_arbiter #(
      .N (N)
   ) u_arb (
      .clk_i     (clk_in),
      .rst_i     (rst_in),
      .req_i     (bus.miss_valid),
      .advance_i (grant_fire),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_pos_d    = req_pos_q;
      req_port_d   = req_port_q;
      mem_en_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      fill_valid_d = 1'b0;
      fill_port_d  = fill_port_q;
      fill_pos_d   = fill_pos_q;
      fill_block_d = fill_block_q;
      case (state_q)
         StIdle: begin
            if (gnt_any) begin
               req_pos_d  = gnt_pos;
               req_port_d = gnt_idx;
               // Invalid positions never touch memory; answer with air straight away.
               if (pos_is_invalid(gnt_pos)) begin
                  state_d      = StFill;
                  fill_valid_d = 1'b1;
                  fill_port_d  = gnt_idx;
                  fill_pos_d   = gnt_pos;
                  fill_block_d = BLOCK_AIR;
               end else begin
                  state_d    = StIssue;
                  mem_en_d   = 1'b1;
                  mem_addr_d = block_pos_to_addr(gnt_pos);
               end
            end
         end
         StIssue: begin
            state_d = StWait;
            cnt_d   = '0;
         end
         StWait: begin
            if (cnt_q == CntW'(BRAM_LATENCY - 1)) begin
               state_d      = StFill;
               fill_valid_d = 1'b1;
               fill_port_d  = req_port_q;
               fill_pos_d   = req_pos_q;
               fill_block_d = bus.mem_data;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFill: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         req_pos_q    <= '{x: TAG_INVALID, y: TAG_INVALID, z: TAG_INVALID};
         req_port_q   <= '0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
         fill_valid_q <= 1'b0;
         fill_port_q  <= '0;
         fill_pos_q   <= '{x: TAG_INVALID, y: TAG_INVALID, z: TAG_INVALID};
         fill_block_q <= BLOCK_AIR;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_pos_q    <= req_pos_d;
         req_port_q   <= req_port_d;
         mem_en_q     <= mem_en_d;
         mem_addr_q   <= mem_addr_d;
         fill_valid_q <= fill_valid_d;
         fill_port_q  <= fill_port_d;
         fill_pos_q   <= fill_pos_d;
         fill_block_q <= fill_block_d;
      end
   end

   assign bus.miss_ready = (state_q == StIdle) ? gnt : '0;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.fill_valid = fill_valid_q;
   assign bus.fill_port  = fill_port_q;
   assign bus.fill_pos   = fill_pos_q;
   assign bus.fill_block = fill_block_q;
   assign bus.busy       = (state_q != StIdle);

endmodule
